ahb_apb_bridge: RTL and testbench

//  AHB-Lite slave to APB4 master bridge; upstream stage feeding the per-peripheral APB register-bus adapters (UART etc.).

---
 rtl/ahb_apb_bridge_pkg.sv | 9 +
 rtl/ahb_apb_bridge_if.sv | 34 +++
 rtl/ahb_apb_addr_decode.sv | 17 +
 rtl/ahb_apb_bridge.sv | 158 +++++++++++++++
 tb/tb_ahb_apb_bridge.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/ahb_apb_bridge_pkg.sv
// ahb_apb_bridge_pkg: FSM states, AHB encodings and byte-strobe helper for the AHB-to-APB bridge
package ahb_apb_bridge_pkg;
  typedef enum logic [2:0] {IDLE, WWAIT, SETUP, ACCESS, ERR1, ERR2} state_e;
  localparam logic [1:0] HTRANS_IDLE = 2'b00, HTRANS_BUSY = 2'b01, HTRANS_NONSEQ = 2'b10, HTRANS_SEQ = 2'b11;
  localparam logic HRESP_OKAY = 1'b0, HRESP_ERROR = 1'b1;
  function automatic logic [3:0] strb_f(input logic [2:0] size, input logic [1:0] a);
    return size == 3'd0 ? 4'b0001 << a : size == 3'd1 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
endpackage

// File: rtl/ahb_apb_bridge_if.sv
// ahb_apb_bridge_if: AHB-Lite slave side and APB4 master side of the bridge
interface ahb_apb_bridge_if #(parameter int ADDR_W = 12, parameter int NUM_SLAVES = 4);
  logic                     ahb_hsel;
  logic [31:0]              ahb_haddr;
  logic [1:0]               ahb_htrans;
  logic                     ahb_hwrite;
  logic [2:0]               ahb_hsize;
  logic [31:0]              ahb_hwdata;
  logic                     ahb_hready;
  logic                     ahb_hreadyout;
  logic                     ahb_hresp;
  logic [31:0]              ahb_hrdata;
  logic [ADDR_W-1:0]        apb_paddr;
  logic [NUM_SLAVES-1:0]    apb_psel;
  logic                     apb_penable;
  logic                     apb_pwrite;
  logic [31:0]              apb_pwdata;
  logic [3:0]               apb_pstrb;
  logic [NUM_SLAVES*32-1:0] apb_prdata;
  logic [NUM_SLAVES-1:0]    apb_pready;
  logic [NUM_SLAVES-1:0]    apb_pslverr;
  modport slave (
    input  ahb_hsel, ahb_haddr, ahb_htrans, ahb_hwrite, ahb_hsize, ahb_hwdata, ahb_hready,
    output ahb_hreadyout, ahb_hresp, ahb_hrdata,
    output apb_paddr, apb_psel, apb_penable, apb_pwrite, apb_pwdata, apb_pstrb,
    input  apb_prdata, apb_pready, apb_pslverr
  );
  modport master (
    output ahb_hsel, ahb_haddr, ahb_htrans, ahb_hwrite, ahb_hsize, ahb_hwdata, ahb_hready,
    input  ahb_hreadyout, ahb_hresp, ahb_hrdata,
    input  apb_paddr, apb_psel, apb_penable, apb_pwrite, apb_pwdata, apb_pstrb,
    output apb_prdata, apb_pready, apb_pslverr
  );
endinterface

// File: rtl/ahb_apb_addr_decode.sv
// ahb_apb_addr_decode: slave index, one-hot select and decode error from address and transfer size
module ahb_apb_addr_decode #(
  parameter int ADDR_W     = 12,
  parameter int NUM_SLAVES = 4
) (
  input  logic [31:0]           haddr,
  input  logic [2:0]            hsize,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  err
);
  logic [3:0] idx;
  always_comb begin
    idx = haddr[ADDR_W+3:ADDR_W];
    err = 32'(idx) >= NUM_SLAVES || hsize > 3'd2 || (hsize == 3'd1 && haddr[0]) || (hsize == 3'd2 && |haddr[1:0]);
    sel = err ? '0 : NUM_SLAVES'(1) << idx;
  end
endmodule

// File: rtl/ahb_apb_bridge.sv
// ahb_apb_bridge: AHB-Lite slave to APB4 master, one transfer at a time; APB_TIMEOUT_EN adds an ACCESS timeout
module ahb_apb_bridge
  import ahb_apb_bridge_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int NUM_SLAVES  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input logic             apb_pclk,
  input logic             apb_presetn,
  ahb_apb_bridge_if.slave bus
);
  state_e                state_q, state_d;
  logic                  hreadyout_q, hreadyout_d, hresp_q, hresp_d;
  logic [31:0]           hrdata_q, hrdata_d, pwdata_q, pwdata_d;
  logic [ADDR_W-1:0]     paddr_q, paddr_d;
  logic [NUM_SLAVES-1:0] psel_q, psel_d, sel_q, sel_d, dec_sel;
  logic                  penable_q, penable_d, pwrite_q, pwrite_d;
  logic [3:0]            pstrb_q, pstrb_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            lsb_q, lsb_d;
  logic [31:0]           prdata_sel;
  logic                  dec_err, accept, rdy, err;
`ifdef APB_TIMEOUT_EN
  logic [7:0]            cnt_q, cnt_d;
`endif
  ahb_apb_addr_decode #(.ADDR_W(ADDR_W), .NUM_SLAVES(NUM_SLAVES)) u_dec (
    .haddr(bus.ahb_haddr), .hsize(bus.ahb_hsize), .sel(dec_sel), .err(dec_err)
  );
  // only the latched slave's response is ever looked at
  always_comb begin
    accept = bus.ahb_hsel && bus.ahb_hready && bus.ahb_htrans[1];
    rdy = |(bus.apb_pready & sel_q);
    err = |(bus.apb_pslverr & sel_q);
    prdata_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) prdata_sel |= bus.apb_prdata[32*i +: 32] & {32{sel_q[i]}};
  end
  always_comb begin
    state_d = state_q;
    hreadyout_d = 1'b1;
    hresp_d = HRESP_OKAY;
    hrdata_d = hrdata_q;
    paddr_d = paddr_q;
    psel_d = '0;
    penable_d = 1'b0;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    pstrb_d = pstrb_q;
    sel_d = sel_q;
    size_d = size_q;
    lsb_d = lsb_q;
`ifdef APB_TIMEOUT_EN
    cnt_d = cnt_q;
`endif
    case (state_q)
      IDLE: if (accept) begin
        state_d = dec_err ? ERR1 : bus.ahb_hwrite ? WWAIT : SETUP;
        hreadyout_d = 1'b0;
        hresp_d = dec_err;
        paddr_d = bus.ahb_haddr[ADDR_W-1:0];
        pwrite_d = bus.ahb_hwrite;
        pstrb_d = '0;
        sel_d = dec_sel;
        size_d = bus.ahb_hsize;
        lsb_d = bus.ahb_haddr[1:0];
        psel_d = bus.ahb_hwrite ? '0 : dec_sel;
      end
      WWAIT: begin
        state_d = SETUP;
        hreadyout_d = 1'b0;
        pwdata_d = bus.ahb_hwdata;
        pstrb_d = strb_f(size_q, lsb_q);
        psel_d = sel_q;
      end
      SETUP: begin
        state_d = ACCESS;
        hreadyout_d = 1'b0;
        psel_d = sel_q;
        penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      ACCESS: if (rdy) begin
        state_d = err ? ERR1 : IDLE;
        hresp_d = err;
        hreadyout_d = !err;
        hrdata_d = (err || pwrite_q) ? hrdata_q : prdata_sel;
      end else begin
        hreadyout_d = 1'b0;
`ifdef APB_TIMEOUT_EN
        if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
          state_d = ERR1;
          hresp_d = HRESP_ERROR;
        end else begin
          cnt_d = cnt_q + 8'd1;
          psel_d = sel_q;
          penable_d = 1'b1;
        end
`else
        psel_d = sel_q;
        penable_d = 1'b1;
`endif
      end
      ERR1: begin
        state_d = ERR2;
        hresp_d = HRESP_ERROR;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge apb_pclk or negedge apb_presetn) begin
    if (!apb_presetn) begin
      state_q <= IDLE;
      hreadyout_q <= 1'b1;
      hresp_q <= HRESP_OKAY;
      hrdata_q <= '0;
      paddr_q <= '0;
      psel_q <= '0;
      penable_q <= 1'b0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q <= '0;
      sel_q <= '0;
      size_q <= '0;
      lsb_q <= '0;
`ifdef APB_TIMEOUT_EN
      cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      hreadyout_q <= hreadyout_d;
      hresp_q <= hresp_d;
      hrdata_q <= hrdata_d;
      paddr_q <= paddr_d;
      psel_q <= psel_d;
      penable_q <= penable_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      pstrb_q <= pstrb_d;
      sel_q <= sel_d;
      size_q <= size_d;
      lsb_q <= lsb_d;
`ifdef APB_TIMEOUT_EN
      cnt_q <= cnt_d;
`endif
    end
  end
  assign bus.ahb_hreadyout = hreadyout_q;
  assign bus.ahb_hresp = hresp_q;
  assign bus.ahb_hrdata = hrdata_q;
  assign bus.apb_paddr = paddr_q;
  assign bus.apb_psel = psel_q;
  assign bus.apb_penable = penable_q;
  assign bus.apb_pwrite = pwrite_q;
  assign bus.apb_pwdata = pwdata_q;
  assign bus.apb_pstrb = pstrb_q;
endmodule

// File: tb/tb_ahb_apb_bridge.sv
// tb_ahb_apb_bridge: scoreboard bench for the AHB-to-APB bridge (AHB and APB sides checked by separate monitors)
module tb_ahb_apb_bridge;
  localparam int AW = 12, NS = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  ahb_apb_bridge_if #(.ADDR_W(AW), .NUM_SLAVES(NS)) bus();
  ahb_apb_bridge #(.ADDR_W(AW), .NUM_SLAVES(NS), .TIMEOUT_CYC(8)) dut (
    .apb_pclk(clk), .apb_presetn(rst_n), .bus(bus)
  );
  typedef struct { logic resp; logic [31:0] rdata; bit chk; int lat; int issue; } ahb_exp_t;
  typedef struct { logic [AW-1:0] paddr; logic [NS-1:0] psel; logic pwrite; logic [31:0] pwdata; logic [3:0] pstrb; } apb_exp_t;
  ahb_exp_t ahb_q[$];
  apb_exp_t apb_q[$];
  int total = 0, bad = 0, cyc = 0, pen_cyc = 0, psel_cyc = 0, acc = 0, wait_n = 0;
  bit slv_err = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask
  task automatic chk_reset(input string t);
    chk({t, "_hreadyout"}, bus.ahb_hreadyout, 1);
    chk({t, "_hresp"}, bus.ahb_hresp, 0);
    chk({t, "_hrdata"}, bus.ahb_hrdata, 0);
    chk({t, "_psel"}, bus.apb_psel, 0);
    chk({t, "_penable"}, bus.apb_penable, 0);
    chk({t, "_pwrite"}, bus.apb_pwrite, 0);
    chk({t, "_paddr"}, bus.apb_paddr, 0);
    chk({t, "_pwdata"}, bus.apb_pwdata, 0);
    chk({t, "_pstrb"}, bus.apb_pstrb, 0);
  endtask
  // AHB monitor: a transfer completes when hreadyout rises
  initial begin
    logic prev_rdy, prev_resp;
    ahb_exp_t e;
    prev_rdy = 1'b1;
    prev_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_rdy = 1'b1;
        prev_resp = 1'b0;
      end else begin
        if (bus.apb_penable) pen_cyc++;
        if (|bus.apb_psel) psel_cyc++;
        if (!prev_rdy && bus.ahb_hreadyout) begin
          if (ahb_q.size() == 0) begin
            total++; bad++;
            $display("FAIL ahb_unexpected: hresp=%0b hrdata=%h", bus.ahb_hresp, bus.ahb_hrdata);
          end else begin
            e = ahb_q.pop_front();
            chk("hresp", bus.ahb_hresp, e.resp);
            if (e.resp) chk("hresp_first_cycle", prev_resp, 1);
            if (e.chk) chk("hrdata", bus.ahb_hrdata, e.rdata);
            chk("latency", cyc - e.issue, e.lat);
          end
        end
        prev_rdy = bus.ahb_hreadyout;
        prev_resp = bus.ahb_hresp;
      end
    end
  end
  // APB slave responder and APB monitor; unselected slaves answer ready+error to prove masking
  initial begin
    apb_exp_t a;
    bus.apb_pready = '1;
    bus.apb_pslverr = '0;
    forever begin
      @(negedge clk);
      acc = (|bus.apb_psel && bus.apb_penable) ? acc + 1 : 0;
      bus.apb_pready = (acc > wait_n) ? '1 : ~bus.apb_psel;
      bus.apb_pslverr = slv_err ? '1 : ~bus.apb_psel;
      if (rst_n && |bus.apb_psel && !bus.apb_penable && apb_q.size() > 0) begin
        a = apb_q[0];
        chk("setup_paddr", bus.apb_paddr, a.paddr);
        chk("setup_psel", bus.apb_psel, a.psel);
        chk("setup_pwrite", bus.apb_pwrite, a.pwrite);
      end
      if (rst_n && |bus.apb_psel && bus.apb_penable && |(bus.apb_pready & bus.apb_psel)) begin
        if (apb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL apb_unexpected: paddr=%h psel=%b", bus.apb_paddr, bus.apb_psel);
        end else begin
          a = apb_q.pop_front();
          chk("paddr", bus.apb_paddr, a.paddr);
          chk("psel", bus.apb_psel, a.psel);
          chk("pwrite", bus.apb_pwrite, a.pwrite);
          chk("pstrb", bus.apb_pstrb, a.pstrb);
          if (a.pwrite) chk("pwdata", bus.apb_pwdata, a.pwdata);
        end
      end
    end
  end
  task automatic wait_done(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      if (ahb_q.size() == 0) return;
    end
    total++; bad++;
    $display("FAIL xfer_timeout: pending=%0d", ahb_q.size());
    ahb_q.delete();
  endtask
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size, input logic [31:0] wdata,
                      input bit apb, input logic [NS-1:0] sel, input logic [3:0] strb,
                      input logic resp, input logic [31:0] rdata, input int lat, input bit gap);
    ahb_exp_t e;
    apb_exp_t a;
    bus.ahb_hsel = 1'b1; bus.ahb_haddr = addr; bus.ahb_htrans = 2'b10; bus.ahb_hwrite = wr; bus.ahb_hsize = size;
    e.resp = resp; e.rdata = rdata; e.chk = !wr && !resp; e.lat = lat; e.issue = cyc;
    ahb_q.push_back(e);
    if (apb) begin
      a.paddr = addr[AW-1:0]; a.psel = sel; a.pwrite = wr; a.pwdata = wdata; a.pstrb = wr ? strb : 4'b0;
      apb_q.push_back(a);
    end
    @(negedge clk);
    bus.ahb_hsel = 1'b0; bus.ahb_htrans = 2'b00; bus.ahb_hwdata = wdata;
    wait_done(60);
    if (gap) @(negedge clk);
  endtask
  initial begin
    int p0;
    bus.ahb_hsel = 1'b0; bus.ahb_haddr = '0; bus.ahb_htrans = 2'b00; bus.ahb_hwrite = 1'b0;
    bus.ahb_hsize = 3'd2; bus.ahb_hwdata = '0; bus.ahb_hready = 1'b1;
    bus.apb_prdata = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h00C0_FFEE};
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    xfer(32'h0000_1004, 0, 3'd2, 0, 1, 4'b0010, 0, 0, 32'hDEAD_BEEF, 3, 0);
    xfer(32'h0000_0008, 0, 3'd2, 0, 1, 4'b0001, 0, 0, 32'h00C0_FFEE, 3, 1);
    xfer(32'h0000_0003, 1, 3'd0, 32'hAA00_0000, 1, 4'b0001, 4'b1000, 0, 0, 4, 1);
    chk("hrdata_hold_after_write", bus.ahb_hrdata, 32'h00C0_FFEE);
    xfer(32'h0000_2002, 1, 3'd1, 32'h1234_0000, 1, 4'b0100, 4'b1100, 0, 0, 4, 0);
    xfer(32'h0000_3FFC, 1, 3'd2, 32'hCAFE_F00D, 1, 4'b1000, 4'b1111, 0, 0, 4, 1);
    xfer(32'h0000_3010, 0, 3'd2, 0, 1, 4'b1000, 0, 0, 32'h3333_3333, 3, 1);
    wait_n = 5;
    p0 = pen_cyc;
    xfer(32'h0000_0000, 0, 3'd2, 0, 1, 4'b0001, 0, 0, 32'h00C0_FFEE, 8, 1);
    chk("wait_penable_cycles", pen_cyc - p0, 6);
    wait_n = 2;
    xfer(32'h0000_2001, 1, 3'd0, 32'h0000_5A00, 1, 4'b0100, 4'b0010, 0, 0, 6, 1);
    wait_n = 0;
    slv_err = 1'b1;
    xfer(32'h0000_1000, 0, 3'd2, 0, 1, 4'b0010, 0, 1, 0, 4, 1);
    xfer(32'h0000_2004, 1, 3'd2, 32'h0BAD_0BAD, 1, 4'b0100, 4'b1111, 1, 0, 5, 1);
    slv_err = 1'b0;
    p0 = psel_cyc;
    xfer(32'h0000_5000, 0, 3'd2, 0, 0, 0, 0, 1, 0, 2, 1);
    xfer(32'h0000_0001, 1, 3'd1, 32'h1, 0, 0, 0, 1, 0, 2, 1);
    xfer(32'h0000_0002, 0, 3'd2, 0, 0, 0, 0, 1, 0, 2, 1);
    xfer(32'h0000_0000, 0, 3'd3, 0, 0, 0, 0, 1, 0, 2, 1);
    chk("decode_err_no_psel", psel_cyc - p0, 0);
    p0 = psel_cyc;
    bus.ahb_hsel = 1'b1; bus.ahb_haddr = 32'h1000; bus.ahb_htrans = 2'b01;
    @(negedge clk);
    bus.ahb_htrans = 2'b10; bus.ahb_hready = 1'b0;
    @(negedge clk);
    bus.ahb_hsel = 1'b0; bus.ahb_htrans = 2'b00; bus.ahb_hready = 1'b1;
    repeat (2) @(negedge clk);
    chk("busy_noready_hreadyout", bus.ahb_hreadyout, 1);
    chk("busy_noready_no_psel", psel_cyc - p0, 0);
    xfer(32'h0000_1004, 0, 3'd2, 0, 1, 4'b0010, 0, 0, 32'hDEAD_BEEF, 3, 1);
    wait_n = 1000;
`ifdef APB_TIMEOUT_EN
    xfer(32'h0000_1000, 0, 3'd2, 0, 0, 0, 0, 1, 0, 11, 1);
    chk("timeout_psel_dropped", bus.apb_psel, 0);
`endif
    bus.ahb_hsel = 1'b1; bus.ahb_haddr = 32'h0000_1008; bus.ahb_htrans = 2'b10; bus.ahb_hwrite = 1'b0;
    @(negedge clk);
    bus.ahb_hsel = 1'b0; bus.ahb_htrans = 2'b00;
`ifdef APB_TIMEOUT_EN
    repeat (3) @(negedge clk);
`else
    repeat (300) @(negedge clk);
`endif
    chk("pending_hreadyout", bus.ahb_hreadyout, 0);
    chk("pending_penable", bus.apb_penable, 1);
    chk("pending_psel", bus.apb_psel, 4'b0010);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_reset("midreset");
    ahb_q.delete();
    apb_q.delete();
    repeat (2) @(negedge clk);
    wait_n = 0;
    rst_n = 1'b1;
    @(negedge clk);
    xfer(32'h0000_1004, 0, 3'd2, 0, 1, 4'b0010, 0, 0, 32'hDEAD_BEEF, 3, 1);
    chk("apb_q_left", apb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
